// File: rtl/dna_report_streamer_if.sv
// rtl/dna_report_streamer_if.sv - byte stream toward the host TX path
// Carries one byte per transfer; a transfer happens on tx_valid && tx_ready at a rising edge.
interface dna_report_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dna_report_streamer.sv
// rtl/dna_report_streamer.sv - frames the device-DNA word as a byte report on host request
// Sends HEADER_BYTE then NUM_BYTES snapshot bytes MSB first, or NOT_READY_BYTE before the DNA is read.
module dna_report_streamer #(
  parameter int unsigned NUM_BYTES      = 8,
  parameter logic [7:0]  HEADER_BYTE    = 8'h44,
  parameter logic [7:0]  NOT_READY_BYTE = 8'h3F
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  dna_in,
  input  logic                         report_req,
  dna_report_streamer_if.master        tx,
  output logic                         busy,
  output logic                         dna_valid
);

  localparam int unsigned CNT_W       = 3;
  localparam logic [3:0]  DONE_NIBBLE = 4'h1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_PAY,
    SEND_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             dna_valid_q, dna_valid_d;
  logic             xfer;

  assign xfer        = tx_valid_q && tx.tx_ready;
  assign dna_valid_d = dna_valid_q || (dna_in[63:60] == DONE_NIBBLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= 64'd0;
      cnt_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      dna_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      dna_valid_q <= dna_valid_d;
    end
  end

  // Requests use the registered dna_valid, so one arriving as the flag first rises gets NOT_READY.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    unique case (state_q)
      IDLE: begin
        if (report_req) begin
          tx_valid_d = 1'b1;
          if (dna_valid_q) begin
            shreg_d   = dna_in;
            cnt_d     = LAST_IDX;
            tx_data_d = HEADER_BYTE;
            state_d   = SEND_HDR;
          end else begin
            tx_data_d = NOT_READY_BYTE;
            state_d   = SEND_ERR;
          end
        end
      end

      SEND_HDR: begin
        if (xfer) begin
          tx_data_d = shreg_q[63:56];
          shreg_d   = shreg_q << 8;
          state_d   = SEND_PAY;
        end
      end

      SEND_PAY: begin
        if (xfer) begin
          if (cnt_q != '0) begin
            tx_data_d = shreg_q[63:56];
            shreg_d   = shreg_q << 8;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      SEND_ERR: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state_q != IDLE);
  assign dna_valid   = dna_valid_q;

endmodule

// File: tb/tb_dna_report_streamer.sv
// tb/tb_dna_report_streamer.sv - table-driven bench for dna_report_streamer
// Each vector: drive inputs, clock once, then compare outputs 1 time unit after the edge.
module tb_dna_report_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] dna_in, dna_b;
  logic        report_req, req_b;
  logic        busy, dna_valid, busy_b, dna_valid_b;

  dna_report_streamer_if tx_a ();
  dna_report_streamer_if tx_b ();

  dna_report_streamer #(.NUM_BYTES(8)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .dna_in     (dna_in),
    .report_req (report_req),
    .tx         (tx_a),
    .busy       (busy),
    .dna_valid  (dna_valid)
  );

  dna_report_streamer #(.NUM_BYTES(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .dna_in     (dna_b),
    .report_req (req_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .dna_valid  (dna_valid_b)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        rdy;
    logic [63:0] dna;
    logic        ev;
    logic [7:0]  ed;
    logic        eb;
    logic        edv;
  } vec_t;

  vec_t        vq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  f1 [9];
  logic [7:0]  f5 [9];
  logic [7:0]  f6 [5];
  int          pat [17];
  logic [7:0]  got[$];

  localparam logic [63:0] D0 = 64'h0;
  localparam logic [63:0] D1 = 64'h1012_3456_789A_BCDE;
  localparam logic [63:0] DX = 64'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] D5 = 64'h1FED_CBA9_8765_4321;

  task automatic v(input logic rst, input logic req, input logic rdy, input logic [63:0] dna,
                   input logic ev, input logic [7:0] ed, input logic eb, input logic edv);
    vec_t t;
    t.rst = rst; t.req = req; t.rdy = rdy; t.dna = dna;
    t.ev = ev; t.ed = ed; t.eb = eb; t.edv = edv;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    reset = 1'b1; report_req = 1'b0; dna_in = D0; tx_a.tx_ready = 1'b0;
    req_b = 1'b0; dna_b = D0; tx_b.tx_ready = 1'b0;

    f1  = '{8'h44, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
    f5  = '{8'h44, 8'h1F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21};
    f6  = '{8'h44, 8'h10, 8'h00, 8'h00, 8'h00};
    pat = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    // reset state and not-ready reply
    v(1, 0, 0, D0, 0, 8'h00, 0, 0);
    v(0, 0, 0, D0, 0, 8'h00, 0, 0);
    v(0, 1, 1, D0, 1, 8'h3F, 1, 0);
    v(0, 0, 1, D0, 0, 8'h00, 0, 0);
    v(0, 0, 1, D0, 0, 8'h00, 0, 0);
    // request in the cycle dna_valid first rises still sees not-ready
    v(0, 1, 0, D1, 1, 8'h3F, 1, 1);
    v(0, 0, 0, D1, 1, 8'h3F, 1, 1);
    v(0, 0, 1, D1, 0, 8'h00, 0, 1);
    // full frame, back-to-back
    v(0, 1, 1, D1, 1, 8'h44, 1, 1);
    for (int k = 1; k < 9; k++) v(0, 0, 1, D1, 1, f1[k], 1, 1);
    v(0, 0, 1, D1, 0, 8'h00, 0, 1);
    // stalls with tx_ready pattern 1,0,0,1,...
    v(0, 1, 0, D1, 1, 8'h44, 1, 1);
    idx = 0;
    for (int k = 0; k < 17; k++) begin
      if (pat[k] != 0) idx++;
      if (idx < 9) v(0, 0, pat[k][0], D1, 1, f1[idx], 1, 1);
      else         v(0, 0, pat[k][0], D1, 0, 8'h00, 0, 1);
    end
    // dropped requests and dna change mid-frame
    v(0, 1, 1, D1, 1, 8'h44, 1, 1);
    v(0, 0, 1, D1, 1, f1[1], 1, 1);
    v(0, 1, 1, DX, 1, f1[2], 1, 1);
    v(0, 1, 0, DX, 1, f1[2], 1, 1);
    for (int k = 3; k < 9; k++) v(0, 0, 1, DX, 1, f1[k], 1, 1);
    v(0, 1, 1, DX, 0, 8'h00, 0, 1);
    v(0, 0, 1, DX, 0, 8'h00, 0, 1);
    // reset after the third payload byte, then a fresh full frame
    v(0, 1, 1, D5, 1, 8'h44, 1, 1);
    for (int k = 1; k < 4; k++) v(0, 0, 1, D5, 1, f5[k], 1, 1);
    v(1, 0, 1, D5, 0, 8'h00, 0, 0);
    v(0, 0, 1, D5, 0, 8'h00, 0, 1);
    v(0, 1, 1, D5, 1, 8'h44, 1, 1);
    for (int k = 1; k < 9; k++) v(0, 0, 1, D5, 1, f5[k], 1, 1);
    v(0, 0, 1, D5, 0, 8'h00, 0, 1);

    foreach (vq[i]) begin
      reset         = vq[i].rst;
      report_req    = vq[i].req;
      tx_a.tx_ready = vq[i].rdy;
      dna_in        = vq[i].dna;
      tick();
      n_vec++;
      chk($sformatf("vec%0d tx_valid", i), {7'd0, tx_a.tx_valid}, {7'd0, vq[i].ev});
      if (vq[i].ev || vq[i].rst)
        chk($sformatf("vec%0d tx_data", i), tx_a.tx_data, vq[i].ed);
      chk($sformatf("vec%0d busy", i), {7'd0, busy}, {7'd0, vq[i].eb});
      chk($sformatf("vec%0d dna_valid", i), {7'd0, dna_valid}, {7'd0, vq[i].edv});
    end
    reset = 1'b0; report_req = 1'b0;

    // NUM_BYTES = 4 instance: header plus four MSB bytes
    dna_b = 64'h1000_0000_CAFE_F00D;
    tx_b.tx_ready = 1'b1;
    tick();
    n_vec++;
    chk("nb4 dna_valid", {7'd0, dna_valid_b}, 8'd1);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_b.tx_valid) got.push_back(tx_b.tx_data);
      tick();
    end
    n_vec++;
    chk("nb4 frame length", 8'(got.size()), 8'd5);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (k < got.size()) chk($sformatf("nb4 byte%0d", k), got[k], f6[k]);
      else chk($sformatf("nb4 byte%0d missing", k), 8'hXX, f6[k]);
    end
    n_vec++;
    chk("nb4 busy after frame", {7'd0, busy_b}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
